// File: rtl/rr_grant_scheduler_pkg.sv
// Shared constants and state encoding for the round-robin grant scheduler.
package rr_grant_scheduler_pkg;

    localparam int NREQ         = 8;
    localparam int SEL_W        = 3;
    localparam int DEF_MAX_HOLD = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/rr_grant_scheduler_grant_decoder.sv
// 3-to-8 one-hot decoder with enable; all outputs low when disabled.
module grant_decoder
    import rr_grant_scheduler_pkg::*;
(
    input  logic [SEL_W-1:0] i_sel,
    input  logic             i_sel_en,
    output logic [NREQ-1:0]  o_gnt
);

    always_comb begin
        o_gnt = '0;
        if (i_sel_en) begin
            o_gnt[i_sel] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_grant_scheduler.sv
// Round-robin arbiter for 8 requesters with hold timeout and one dead cycle between grants.
// state | meaning
// IDLE  | no owner; arbitrates from ptr when en=1 and any req is high
// GRANT | sel owns the resource until done, req[sel] drop or hold timeout
module rr_grant_scheduler
    import rr_grant_scheduler_pkg::*;
#(
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [NREQ-1:0]  req,
    input  logic             done,
    output logic [SEL_W-1:0] sel,
    output logic             sel_en,
    output logic [NREQ-1:0]  gnt,
    output logic             busy,
    output logic             timeout
);

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [SEL_W-1:0] r_ptr;
    logic [SEL_W-1:0] w_ptr_nxt;
    logic [7:0]       r_hold_cnt;
    logic [7:0]       w_hold_nxt;
    logic [SEL_W-1:0] r_sel;
    logic [SEL_W-1:0] w_sel_nxt;
    logic             r_sel_en;
    logic             w_sel_en_nxt;
    logic             r_timeout;
    logic             w_timeout_nxt;
    logic [SEL_W-1:0] w_winner;
    logic             w_drop;
    logic             w_tc;

    // First requester at or after ptr, wrapping through the 3-bit index.
    always_comb begin : prio_search
        logic             found;
        logic [SEL_W-1:0] idx;
        found    = 1'b0;
        w_winner = r_ptr;
        for (int k = 0; k < NREQ; k++) begin
            idx = r_ptr + SEL_W'(k);
            if (!found && req[idx]) begin
                w_winner = idx;
                found    = 1'b1;
            end
        end
    end

    assign w_drop = ~req[r_sel];
    assign w_tc   = (r_hold_cnt == HOLD_LAST);

    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_hold_nxt    = r_hold_cnt;
        w_sel_nxt     = r_sel;
        w_sel_en_nxt  = r_sel_en;
        w_timeout_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (en && (|req)) begin
                    w_state_nxt  = GRANT;
                    w_sel_nxt    = w_winner;
                    w_sel_en_nxt = 1'b1;
                    w_hold_nxt   = '0;
                end
            end
            GRANT: begin
                if (done || w_drop || w_tc) begin
                    w_state_nxt   = IDLE;
                    w_sel_en_nxt  = 1'b0;
                    w_ptr_nxt     = r_sel + SEL_W'(1);
                    // Pulse only when the hold limit alone ended the grant.
                    w_timeout_nxt = w_tc && !done && !w_drop;
                end else begin
                    w_hold_nxt = r_hold_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt  = IDLE;
                w_sel_en_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_hold_cnt <= '0;
            r_sel      <= '0;
            r_sel_en   <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_sel      <= w_sel_nxt;
            r_sel_en   <= w_sel_en_nxt;
            r_timeout  <= w_timeout_nxt;
        end
    end

    assign sel     = r_sel;
    assign sel_en  = r_sel_en;
    assign busy    = (r_state == GRANT);
    assign timeout = r_timeout;

    grant_decoder u_grant_decoder (
        .i_sel    (r_sel),
        .i_sel_en (r_sel_en),
        .o_gnt    (gnt)
    );

endmodule

// File: doc/rr_grant_scheduler.md
Name: rr_grant_scheduler

Overview:
Round-robin arbiter sharing one resource among 8 requesters. It selects one requester and drives a 3-bit select plus enable into a 3-to-8 one-hot decoder, producing the per-requester grant strobes. Grants are held until the owner signals done, drops its request, or a hold timeout expires. After every grant there is one dead cycle, so grants never overlap.

Parameters:
NREQ, 8, number of requesters; fixed at 8 to match the 3-bit select.
SEL_W, 3, select width; must equal log2(NREQ).
MAX_HOLD, 16, maximum cycles a grant may be held; legal range 1..255.

Ports:
clk  input  1  clock; all state changes on the rising edge.
rst_n  input  1  reset, synchronous, active-low.
en  input  1  arbitration enable; low blocks new grants.
req  input  8  request vector; bit i belongs to requester i, held high while wanting the resource.
done  input  1  single-cycle release pulse from the current owner.
sel  output  3  index of the current owner; registered.
sel_en  output  1  grant valid; registered.
gnt  output  8  one-hot grant, combinational decode of sel/sel_en; all zero when sel_en=0.
busy  output  1  high while in the GRANT state.
timeout  output  1  one-cycle pulse when a grant is forcibly ended by MAX_HOLD.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, ptr=0, hold_cnt=0.
  - sel=0, sel_en=0, gnt=0, busy=0, timeout=0.
  - Reset applied mid-grant aborts the grant at that edge, with no timeout pulse.
- ptr is the highest-priority index. Winner = first i, searching ptr, ptr+1, … mod 8, with req[i]=1.
- IDLE:
  - If en=1 and req!=0 at an edge: state→GRANT, sel=winner, sel_en=1, hold_cnt=0.
  - Latency from a req sample to gnt high is 1 cycle.
  - If en=0 or req=0: remain in IDLE.
  - done is ignored in IDLE.
- GRANT:
  - hold_cnt increments each cycle.
  - Exit conditions, evaluated at each edge:
    - (a) done=1.
    - (b) req[sel]=0.
    - (c) hold_cnt==MAX_HOLD-1.
  - On exit: state→IDLE, sel_en=0, ptr=(sel+1) mod 8 (7 wraps to 0); sel retains its value.
  - timeout=1 for the following cycle only when (c) is the sole cause. If done or a req drop coincides with (c), there is no timeout pulse.
  - en going low during GRANT does not abort the grant; it only prevents the next one.
  - Changes to other req bits during GRANT have no effect.
- Dead cycle: the IDLE cycle after an exit always has gnt=0. Arbitration happens in that cycle, so the minimum gap between consecutive grants is exactly 1 cycle.
- Grant length: with continuous req and no done, gnt stays high exactly MAX_HOLD cycles. MAX_HOLD=1 gives single-cycle grants.
- gnt decode: gnt[i]=1 iff sel_en=1 and sel==i. Exactly one bit or zero bits are set; never more.
- Fairness: with all 8 requesting continuously, the grant order is 0,1,…,7,0. No requester waits more than 7 grants.

Decomposition:
- Shared package holds:
  - NREQ and SEL_W constants.
  - State enum: IDLE=1'b0, GRANT=1'b1.
  - Default MAX_HOLD.
- One sub-module, grant_decoder: purely combinational 3-to-8 one-hot decoder with enable (sel, sel_en → gnt). It outputs zero when disabled.
- The top level contains:
  - the FSM;
  - ptr and hold_cnt registers;
  - the rotating priority search.

Test Plan:
1. Reset mid-grant: grant to req=8'h01, assert rst_n=0 for 1 edge → next cycle sel=0, sel_en=0, gnt=0, busy=0, timeout=0, ptr=0.
2. Single requester with done: req=8'h10, done pulsed on the 3rd GRANT cycle → gnt=8'h10 for 3 cycles, 1 dead cycle, then re-grant 8'h10 (ptr=5, 4 is the only requester).
3. Round-robin wrap: req=8'hFF held, done pulsed every grant cycle → gnt sequence 01,00,02,00,04,…,80,00,01; ptr wraps from 7 to 0.
4. Timeout: MAX_HOLD=4, req=8'h04 held, no done → gnt=8'h04 for 4 cycles, timeout=1 in the next cycle only, then re-grant after 1 dead cycle.
5. Simultaneous done and timeout: MAX_HOLD=4, done on the 4th grant cycle → exit with timeout=0.
6. en gating and req drop: en=0 with req=8'h81 → no grant. en=1 → gnt=8'h01. Drop req[0] → gnt=0 next cycle, then gnt=8'h80.
